// File: rtl/lcm_pkg.sv
// lcm_pkg -- shared types and constants for the LCM unit.
//   state_t       : controller phases IDLE -> GCD -> DIV -> MUL.
//   DEFAULT_WIDTH : default operand width.
//   RESULT_WIDTH  : result width for the default operand width.
//   result_width(): result width (2*w) for any operand width w.
package lcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GCD  = 2'd1,
    DIV  = 2'd2,
    MUL  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int RESULT_WIDTH  = 2 * DEFAULT_WIDTH;

  function automatic int result_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/lcm_calc_if.sv
// lcm_calc_if -- request/result bundle of the LCM unit.
//   start     : one-cycle request (master -> slave)
//   a, b      : WIDTH-bit operands (master -> slave)
//   busy      : operation in progress (slave -> master)
//   lcm_out   : 2*WIDTH-bit result (slave -> master)
//   lcm_valid : result valid (slave -> master)
//   gcd_out   : WIDTH-bit gcd, present only when LCM_GCD_OUT_EN is defined
interface lcm_calc_if #(
  parameter int WIDTH = lcm_pkg::DEFAULT_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic [2*WIDTH-1:0]   lcm_out;
  logic                 lcm_valid;
`ifdef LCM_GCD_OUT_EN
  logic [WIDTH-1:0]     gcd_out;

  modport master (output start, a, b, input busy, lcm_out, lcm_valid, gcd_out);
  modport slave  (input start, a, b, output busy, lcm_out, lcm_valid, gcd_out);
`else
  modport master (output start, a, b, input busy, lcm_out, lcm_valid);
  modport slave  (input start, a, b, output busy, lcm_out, lcm_valid);
`endif
endinterface

// File: rtl/lcm_calc_seq_shift_add_mul.sv
// seq_shift_add_mul -- sequential shift-add multiplier, one multiplier bit
// per cycle, exactly WIDTH step cycles after a load.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture operands and start (ignored state is overwritten)
//   mcand_i    : WIDTH-bit multiplicand
//   mplier_i   : WIDTH-bit multiplier
//   product_o  : 2*WIDTH-bit product, final when done_o is high
//   done_o     : one-cycle pulse after the last step edge
module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 done_o
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic               done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      cnt_q    <= '0;
      run_q    <= 1'b1;
      done_q   <= 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign product_o = acc_q;
  assign done_o    = done_q;

endmodule

// File: rtl/lcm_calc.sv
// lcm_calc -- sequential least common multiple of two unsigned operands.
// Flow: subtractive GCD g, restoring divide q = a/g (WIDTH cycles), then
// shift-add multiply q*b (WIDTH cycles) in seq_shift_add_mul.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : lcm_calc_if.slave (start, a, b, busy, lcm_out, lcm_valid
//           and gcd_out when LCM_GCD_OUT_EN is defined)
// Optional macro LCM_GCD_OUT_EN exposes the computed gcd on bus.gcd_out.
module lcm_calc
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  lcm_calc_if.slave  bus
);
  localparam int RES_W = result_width(WIDTH);
  localparam int CW    = $clog2(WIDTH);

  state_t             state_q;
  logic [WIDTH-1:0]   x_q, y_q;     // GCD working pair
  logic [WIDTH-1:0]   a_q;          // dividend, shifts into the quotient
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   g_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      div_cnt_q;
  logic               busy_q;
  logic               valid_q;
  logic [RES_W-1:0]   lcm_out_q;
`ifdef LCM_GCD_OUT_EN
  logic [WIDTH-1:0]   gcd_out_q;
`endif

  // Restoring-division step. The partial remainder never exceeds g-1, so
  // one extra bit on the shifted remainder is enough for the compare.
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               div_last;
  logic               mul_load;
  logic [RES_W-1:0]   mul_product;
  logic               mul_done;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    rem_shift = {rem_q, a_q[WIDTH-1]};
    rem_d     = rem_shift[WIDTH-1:0];
    quo_d     = {a_q[WIDTH-2:0], 1'b0};
    if (rem_shift >= {1'b0, g_q}) begin
      rem_d = WIDTH'(rem_shift - {1'b0, g_q});
      quo_d = {a_q[WIDTH-2:0], 1'b1};
    end
  end

  assign div_last = (div_cnt_q == CW'(WIDTH - 1));
  // The quotient is complete during the last DIV cycle; hand it straight to
  // the multiplier so its WIDTH steps start on the following edge.
  assign mul_load = (state_q == DIV) && div_last;

  seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load_i    (mul_load),
    .mcand_i   (quo_d),
    .mplier_i  (b_q),
    .product_o (mul_product),
    .done_o    (mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register, datapath included, is cleared so an aborted
      // operation leaves nothing behind.
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      g_q       <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      lcm_out_q <= '0;
`ifdef LCM_GCD_OUT_EN
      gcd_out_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.a != '0 && bus.b != '0) begin
              x_q     <= bus.a;
              y_q     <= bus.b;
              a_q     <= bus.a;
              b_q     <= bus.b;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
              state_q <= GCD;
            end else begin
              // lcm with a zero operand is defined as zero; no busy phase.
              lcm_out_q <= '0;
              valid_q   <= 1'b1;
`ifdef LCM_GCD_OUT_EN
              gcd_out_q <= '0;
`endif
            end
          end
        end
        GCD: begin
          // The larger value is always the minuend, so no underflow.
          if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else if (y_q > x_q) begin
            y_q <= y_q - x_q;
          end else begin
            g_q       <= x_q;
            rem_q     <= '0;
            div_cnt_q <= '0;
            state_q   <= DIV;
`ifdef LCM_GCD_OUT_EN
            gcd_out_q <= x_q;
`endif
          end
        end
        DIV: begin
          a_q       <= quo_d;
          rem_q     <= rem_d;
          div_cnt_q <= div_cnt_q + CW'(1);
          if (div_last) state_q <= MUL;
        end
        MUL: begin
          if (mul_done) begin
            lcm_out_q <= mul_product;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.lcm_out   = lcm_out_q;
  assign bus.lcm_valid = valid_q;
`ifdef LCM_GCD_OUT_EN
  assign bus.gcd_out   = gcd_out_q;
`endif

endmodule

// File: tb/tb_lcm_calc.sv
// tb_lcm_calc -- self-checking bench for lcm_calc (WIDTH=8).
// Reference: lcm = (a/gcd)*b using modulo Euclid; the subtraction count is
// the sum of Euclid quotients minus one; latency = N_sub + 2*WIDTH + 2.
module tb_lcm_calc;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  lcm_calc_if #(.WIDTH(W)) bus ();

  lcm_calc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(input int ia, input int ib,
                                output int lcm, output int g, output int nsub);
    int x, y, t, qsum;
    if (ia == 0 || ib == 0) begin
      lcm = 0; g = 0; nsub = 0;
      return;
    end
    x = (ia > ib) ? ia : ib;
    y = (ia > ib) ? ib : ia;
    qsum = 0;
    while (y != 0) begin
      qsum += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g    = x;
    lcm  = (ia / g) * ib;
    nsub = qsum - 1;
  endfunction

  // Starts one operation and checks result, latency and handshake.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input string tag);
    int exp_lcm, exp_g, nsub, exp_lat, k;
    model(int'(ia), int'(ib), exp_lcm, exp_g, nsub);
    exp_lat = nsub + 2 * W + 2;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ia; bus.b = ib;
    @(negedge clk);                       // edge 0 has passed
    bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
    if (ia == 0 || ib == 0) begin
      total++;
      if (bus.lcm_valid !== 1'b1 || bus.busy !== 1'b0 || bus.lcm_out !== 16'd0) begin
        bad++;
        $display("FAIL %s zero_path: valid=%b busy=%b out=%0d required valid=1 busy=0 out=0",
                 tag, bus.lcm_valid, bus.busy, bus.lcm_out);
      end
`ifdef LCM_GCD_OUT_EN
      total++;
      if (bus.gcd_out !== 8'd0) begin
        bad++;
        $display("FAIL %s zero_gcd: got %0d required 0", tag, bus.gcd_out);
      end
`endif
      return;
    end
    total++;
    if (bus.busy !== 1'b1 || bus.lcm_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b valid=%b required busy=1 valid=0",
               tag, bus.busy, bus.lcm_valid);
    end
    k = 0;
    while (bus.lcm_valid !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d required %0d", tag, k, exp_lat);
    end
    total++;
    if (bus.lcm_out !== 16'(exp_lcm) || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s result: out=%0d busy=%b required out=%0d busy=0",
               tag, bus.lcm_out, bus.busy, exp_lcm);
    end
`ifdef LCM_GCD_OUT_EN
    total++;
    if (bus.gcd_out !== 8'(exp_g)) begin
      bad++;
      $display("FAIL %s gcd: got %0d required %0d", tag, bus.gcd_out, exp_g);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.lcm_valid !== 1'b0 || bus.lcm_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b valid=%b out=%0d required 0/0/0",
               bus.busy, bus.lcm_valid, bus.lcm_out);
    end
    // reset and start together: reset wins
    bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd3;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.lcm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_with_start: busy=%b valid=%b required 0/0", bus.busy, bus.lcm_valid);
    end
    bus.start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_op(8'd4, 8'd6, "basic_4_6");
    do_op(8'd7, 8'd7, "equal_7_7");
    do_op(8'd6, 8'd8, "basic_6_8");
  endtask

  task automatic test_boundary();
    do_op(8'd255, 8'd254, "max_255_254");
    do_op(8'd0, 8'd9, "zero_a");
    do_op(8'd9, 8'd0, "zero_b");
    do_op(8'd255, 8'd255, "max_equal");
  endtask

  task automatic test_busy_ignore();
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd4; bus.b = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.lcm_valid !== 1'b1 && k < 400) begin
      if (k == 4) begin
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    total++;
    if (k != 20 || bus.lcm_out !== 16'd12) begin
      bad++;
      $display("FAIL busy_ignore: latency=%0d out=%0d required latency=20 out=12", k, bus.lcm_out);
    end
  endtask

  task automatic test_back_to_back();
    do_op(8'd12, 8'd18, "b2b_first");
    total++;
    if (bus.lcm_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_valid_held: got %b required 1", bus.lcm_valid);
    end
    do_op(8'd10, 8'd15, "b2b_second");   // valid must drop on its accept edge
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd255; bus.b = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    for (k = 0; k < 99; k++) @(negedge clk);
    reset = 1'b1;                         // sampled at edge 100
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.lcm_valid !== 1'b0 || bus.lcm_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b valid=%b out=%0d required 0/0/0",
               bus.busy, bus.lcm_valid, bus.lcm_out);
    end
    reset = 1'b0;
    do_op(8'd6, 8'd8, "after_reset_6_8");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      if (i == 5) ra = 8'd0;
      do_op(ra, rb, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
